hostaddr_access_ctrl: RTL and testbench

//  Access controller/arbiter for the single-port host-address table RAM (registered read address, 1-cycle read).

---
 rtl/hostaddr_pkg.sv | 27 ++
 rtl/hostaddr_rr_arb.sv | 33 +++
 rtl/hostaddr_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_hostaddr_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hostaddr_pkg.sv
// Shared types and sizing helpers for the host-address table access controller.
// Default table sizes apply when defines.vh has not already provided them.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 4
`endif
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 12
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 4
`endif

package hostaddr_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } ctrl_state_e;

  localparam int unsigned DEF_NUM_RD          = 4;
  localparam int unsigned DEF_WR_STARVE_LIMIT = 4;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hostaddr_rr_arb.sv
// Round-robin picker: grants the first requester after ptr (wrapping), one-hot plus id.
module hostaddr_rr_arb
  import hostaddr_pkg::*;
#(
  parameter  int unsigned NUM_RD = DEF_NUM_RD,
  localparam int unsigned ID_W   = id_width(NUM_RD)
) (
  input  logic [NUM_RD-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_RD-1:0] gnt,
  output logic [ID_W-1:0]   id
);

  logic        found;
  int unsigned idx;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_RD; k++) begin
      idx = (32'(ptr) + k) % NUM_RD;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hostaddr_access_ctrl.sv
// Single-port host-address RAM access controller: one host write port, NUM_RD lookup readers.
// Optional power-up clear sweep of the whole table when HOSTADDR_CTRL_INIT_EN is defined.
module hostaddr_access_ctrl
  import hostaddr_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH      = `HOST_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH      = `VALUE_DATA_WIDTH + `VALUE_SIZE,
  parameter  int unsigned NUM_RD          = DEF_NUM_RD,
  parameter  int unsigned WR_STARVE_LIMIT = DEF_WR_STARVE_LIMIT,
  localparam int unsigned ID_W            = id_width(NUM_RD)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic                         rsp_valid,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         ram_we,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_data,
  input  logic [DATA_WIDTH-1:0]        ram_q,
  output logic                         busy
);

  localparam int unsigned    CNT_W      = $clog2(WR_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(WR_STARVE_LIMIT);

  logic                  run;
  logic                  sweeping;
  logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef HOSTADDR_CTRL_INIT_EN
  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    busy_d  = busy_q;
    if (state_q == S_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (&sweep_q) begin
        state_d = S_RUN;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
    end
  end

  assign run        = (state_q == S_RUN);
  assign sweeping   = (state_q == S_INIT) && !reset;
  assign sweep_addr = sweep_q;
  assign busy       = busy_q;
`else
  assign run        = 1'b1;
  assign sweeping   = 1'b0;
  assign sweep_addr = '0;
  assign busy       = 1'b0;
`endif

  logic                  live;
  logic                  rd_any, rd_pri, wr_fire, rd_fire;
  logic [NUM_RD-1:0]     rd_gnt;
  logic [ID_W-1:0]       rd_id;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  // Nothing is granted while reset is held, even in the build without the init FSM.
  assign live = run && !reset;

  hostaddr_rr_arb #(
    .NUM_RD (NUM_RD)
  ) u_rr_arb (
    .req (rd_valid),
    .ptr (rr_ptr_q),
    .gnt (rd_gnt),
    .id  (rd_id)
  );

  always_comb begin
    rd_any   = |rd_valid;
    rd_pri   = rd_any && (starve_q == STARVE_MAX);
    wr_fire  = live && wr_valid && !rd_pri;
    rd_fire  = live && rd_any && !wr_fire;
    wr_ready = wr_fire;
    rd_ready = rd_fire ? rd_gnt : '0;

    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (sweeping) begin
      ram_we   = 1'b1;
      ram_addr = sweep_addr;
    end else if (wr_fire) begin
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_data = wr_data;
    end else if (rd_fire) begin
      ram_addr = rd_addr[32'(rd_id)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Counts writes that jumped a waiting read; any read grant or an idle read side clears it.
    starve_d = starve_q;
    if (!rd_any || rd_fire) begin
      starve_d = '0;
    end else if (wr_fire && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    rr_ptr_d    = rd_fire ? rd_id : rr_ptr_q;
    rsp_valid_d = rd_fire;
    rsp_id_d    = rd_fire ? rd_id : rsp_id_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= ID_W'(NUM_RD - 1);
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_q;

endmodule

// File: tb/tb_hostaddr_access_ctrl.sv
// Bench for hostaddr_access_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hostaddr_access_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int N     = 4;
  localparam int LIM   = 4;
  localparam int DEPTH = 1 << AW;
  localparam int IDW   = 2;
`ifdef HOSTADDR_CTRL_INIT_EN
  localparam int INIT_CYCLES = DEPTH;
`else
  localparam int INIT_CYCLES = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [N-1:0]    rd_valid = '0;
  logic [N-1:0]    rd_ready;
  logic [N*AW-1:0] rd_addr = '0;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic [DW-1:0]   ram_q;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hostaddr_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(N), .WR_STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .busy(busy)
  );

  // Single-port RAM with registered read address.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] mem_addr_q = '0;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    mem_addr_q <= ram_addr;
  end
  assign ram_q = mem[mem_addr_q];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  // Behavioural model: table contents, pointer, starvation count, pending response.
  logic [DW-1:0] shadow [DEPTH];
  int            m_ptr = N - 1;
  int            m_starve = 0;
  int            m_init_left = INIT_CYCLES;
  bit            e_valid = 1'b0;
  int            e_id = 0;
  logic [DW-1:0] e_data = '0;
  initial for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

  always @(negedge clk) begin : model
    bit            wg, rg, rd_any;
    int            gid;
    logic [AW-1:0] ra;
    logic [N-1:0]  exp_rdy;
    if (rst) begin
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_ready", rd_ready, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      m_ptr = N - 1;
      m_starve = 0;
      e_valid = 1'b0;
      m_init_left = INIT_CYCLES;
    end else if (m_init_left > 0) begin
      check("init_busy", busy, 1);
      check("init_ram_we", ram_we, 1);
      check("init_ram_addr", ram_addr, DEPTH - m_init_left);
      check("init_ram_data", ram_data, 0);
      check("init_ready", {wr_ready, rd_ready}, 0);
      check("init_rsp_valid", rsp_valid, 0);
      shadow[DEPTH - m_init_left] = '0;
      m_init_left--;
    end else begin
      check("busy", busy, 0);
      check("rsp_valid", rsp_valid, e_valid);
      if (e_valid) begin
        check("rsp_id", rsp_id, e_id);
        check("rsp_data", rsp_data, e_data);
      end
      rd_any = (rd_valid != 0);
      wg = wr_valid && !(rd_any && m_starve == LIM);
      rg = rd_any && !wg;
      gid = 0;
      if (rg) begin
        for (int k = N; k >= 1; k--)
          if (rd_valid[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
      end
      exp_rdy = '0;
      if (rg) exp_rdy[gid] = 1'b1;
      check("wr_ready", wr_ready, wg);
      check("rd_ready", rd_ready, exp_rdy);
      check("ram_we", ram_we, wg);
      if (wg) begin
        check("ram_addr_wr", ram_addr, wr_addr);
        check("ram_data_wr", ram_data, wr_data);
        shadow[wr_addr] = wr_data;
      end
      if (rg) begin
        ra = rd_addr[gid*AW +: AW];
        check("ram_addr_rd", ram_addr, ra);
        e_data = shadow[ra];
        e_id = gid;
        m_ptr = gid;
      end
      e_valid = rg;
      if (!rd_any || rg) m_starve = 0;
      else if (wg) m_starve++;
    end
  end

  task automatic do_reset();
    int cnt = 0;
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_valid = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    while (busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, INIT_CYCLES);
    step();
  endtask

  initial begin : main
    bit            wf;
    logic [N-1:0]  rf;
    logic [N-1:0]  exp_oh;
    int            cnt;

    // 1: write then read the same address
    do_reset();
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    @(negedge clk); check("t1_wr_ready", wr_ready, 1);
    step(); wr_valid = 1'b0; rd_valid = 4'b0001; set_rd(0, 4'd3);
    @(negedge clk); check("t1_rd_ready", rd_ready, 4'b0001);
    step(); rd_valid = '0;
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_data", rsp_data, 16'h1234);
    step();

    // 2: all readers held, round-robin rotation from requester 0
    do_reset();
    rd_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_rd(i, AW'(i + 8));
    for (int k = 0; k < 5; k++) begin
      exp_oh = '0;
      exp_oh[k % N] = 1'b1;
      @(negedge clk); check("t2_rd_ready", rd_ready, exp_oh);
      step();
    end
    rd_valid = '0;

    // 3: writes starve reader 1 for exactly LIM grants
    do_reset();
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'h0100;
    rd_valid = 4'b0010; set_rd(1, 4'd9);
    for (int k = 0; k < LIM; k++) begin
      @(negedge clk);
      check("t3_wr_ready", wr_ready, 1);
      check("t3_rd_blocked", rd_ready, 0);
      step(); wr_data = wr_data + 16'h1;
    end
    @(negedge clk);
    check("t3_wr_held", wr_ready, 0);
    check("t3_rd_ready", rd_ready, 4'b0010);
    step(); rd_valid = '0;
    @(negedge clk);
    check("t3_wr_resume", wr_ready, 1);
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_id", rsp_id, 1);
    step(); wr_valid = 1'b0;

    // 4: simultaneous write and read of the same address
    do_reset();
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    rd_valid = 4'b0100; set_rd(2, 4'd5);
    @(negedge clk);
    check("t4_wr_first", wr_ready, 1);
    check("t4_rd_wait", rd_ready, 0);
    step(); wr_valid = 1'b0;
    @(negedge clk); check("t4_rd_ready", rd_ready, 4'b0100);
    step(); rd_valid = '0;
    @(negedge clk);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_id", rsp_id, 2);
    check("t4_rsp_data", rsp_data, 16'hBEEF);
    step();

    // 5: reset right after a read grant
    do_reset();
    rd_valid = 4'b0010; set_rd(1, 4'd2);
    @(negedge clk); check("t5_rd_ready", rd_ready, 4'b0010);
    step(); rst = 1'b1; rd_valid = '0;
    @(negedge clk);
    check("t5_rsp_dropped", rsp_valid, 0);
    check("t5_rdy_in_rst", rd_ready, 0);
    step(); rst = 1'b0; rd_valid = 4'b1111;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_first_grant", rd_ready, 4'b0001);
    step(); rd_valid = '0;

    // Randomized traffic with occasional reset pulses
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      wf = wr_valid && wr_ready;
      rf = rd_valid & rd_ready;
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 119) == 0) rst = 1'b1;
      if (!wr_valid || wf) begin
        wr_valid = (cyc < 1500) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        wr_addr  = AW'($urandom_range(0, DEPTH - 1));
        wr_data  = DW'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (!rd_valid[i] || rf[i]) begin
          rd_valid[i] = ($urandom_range(0, 2) == 0);
          set_rd(i, AW'($urandom_range(0, DEPTH - 1)));
        end
      end
    end
    wr_valid = 1'b0;
    rd_valid = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
